// File: rtl/ladybird_debug_injector.sv
// ladybird_debug_injector: turns host debug commands (register read/write,
// byte memory read/write) into short RV32I sequences fed one at a time into
// a halted core's injection port, one outstanding instruction and one
// command in flight at a time.
// Optional feature macro: LADYBIRD_INJECT_TIMEOUT_EN bounds every retire
// wait to TIMEOUT cycles and aborts the command with an error when it expires.
module ladybird_debug_injector #(
  parameter logic [4:0] SCRATCH0 = 5'd30,
  parameter logic [4:0] SCRATCH1 = 5'd31,
  parameter int         TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_regno,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  input  logic        core_halted,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  input  logic        retire_valid,
  input  logic [31:0] retire_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_REG_READ   = 2'd0;
  localparam logic [1:0] OP_REG_WRITE  = 2'd1;
  localparam logic [1:0] OP_MEM_READ_B = 2'd2;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // RV32I instruction constructors
  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OPC_OPIMM};
  endfunction

  function automatic logic [31:0] enc_lb(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] enc_sb(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OPC_STORE};
  endfunction

  // One half of a 32-bit constant load: LUI of the biased upper part, then
  // ADDI of the low 12 bits. The +0x800 bias cancels ADDI's sign extension.
  function automatic logic [31:0] ld_step(input logic [4:0] r, input logic [31:0] v,
                                          input logic second);
    logic [31:0] biased;
    biased = v + 32'h0000_0800;
    if (second) return enc_addi(r, r, v[11:0]);
    return enc_lui(r, biased[31:12]);
  endfunction

  state_t      state_reg, state_next;
  logic [3:0]  step_reg, step_next;
  logic [1:0]  op_reg, op_next;
  logic [4:0]  regno_reg, regno_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] save0_reg, save0_next;
  logic [31:0] save1_reg, save1_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic        rsp_error_reg, rsp_error_next;

  logic [31:0] cur_inst;
  logic        step_last;
  logic        cap_rsp;
  logic        cap_save0;
  logic        cap_save1;

`ifdef LADYBIRD_INJECT_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tmo_reg, tmo_next;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Decode the current step of the latched op into an instruction and its flags
  always_comb begin
    cur_inst  = '0;
    step_last = 1'b0;
    cap_rsp   = 1'b0;
    cap_save0 = 1'b0;
    cap_save1 = 1'b0;
    case (op_reg)
      OP_REG_READ: begin
        cur_inst  = enc_addi(regno_reg, regno_reg, 12'h000);
        cap_rsp   = 1'b1;
        step_last = 1'b1;
      end
      OP_REG_WRITE: begin
        cur_inst  = ld_step(regno_reg, data_reg, step_reg[0]);
        step_last = (step_reg == 4'd1);
      end
      OP_MEM_READ_B: begin
        case (step_reg)
          4'd0: begin
            cur_inst  = enc_addi(SCRATCH0, SCRATCH0, 12'h000);
            cap_save0 = 1'b1;
          end
          4'd1: cur_inst = ld_step(SCRATCH0, addr_reg, 1'b0);
          4'd2: cur_inst = ld_step(SCRATCH0, addr_reg, 1'b1);
          4'd3: begin
            cur_inst = enc_lb(SCRATCH0, SCRATCH0, 12'h000);
            cap_rsp  = 1'b1;
          end
          4'd4: cur_inst = ld_step(SCRATCH0, save0_reg, 1'b0);
          default: begin
            cur_inst  = ld_step(SCRATCH0, save0_reg, 1'b1);
            step_last = 1'b1;
          end
        endcase
      end
      default: begin  // MEM_WRITE_B
        case (step_reg)
          4'd0: begin
            cur_inst  = enc_addi(SCRATCH0, SCRATCH0, 12'h000);
            cap_save0 = 1'b1;
          end
          4'd1: begin
            cur_inst  = enc_addi(SCRATCH1, SCRATCH1, 12'h000);
            cap_save1 = 1'b1;
          end
          4'd2: cur_inst = ld_step(SCRATCH0, addr_reg, 1'b0);
          4'd3: cur_inst = ld_step(SCRATCH0, addr_reg, 1'b1);
          4'd4: cur_inst = enc_addi(SCRATCH1, 5'd0, {4'h0, data_reg[7:0]});
          4'd5: cur_inst = enc_sb(SCRATCH1, SCRATCH0, 12'h000);
          4'd6: cur_inst = ld_step(SCRATCH0, save0_reg, 1'b0);
          4'd7: cur_inst = ld_step(SCRATCH0, save0_reg, 1'b1);
          4'd8: cur_inst = ld_step(SCRATCH1, save1_reg, 1'b0);
          default: begin
            cur_inst  = ld_step(SCRATCH1, save1_reg, 1'b1);
            step_last = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Next-state logic: command latch, issue/retire handshakes and response
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    op_next        = op_reg;
    regno_next     = regno_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    save0_next     = save0_reg;
    save1_next     = save1_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_error_next = rsp_error_reg;
`ifdef LADYBIRD_INJECT_TIMEOUT_EN
    tmo_next       = tmo_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          op_next    = cmd_op;
          regno_next = cmd_regno;
          addr_next  = cmd_addr;
          data_next  = cmd_data;
          step_next  = '0;
          if (core_halted) begin
            state_next     = ISSUE;
            rsp_error_next = 1'b0;
            rsp_data_next  = (cmd_op == OP_REG_WRITE) ? cmd_data : 32'h0;
          end else begin
            state_next     = RESP;
            rsp_error_next = 1'b1;
            rsp_data_next  = 32'h0;
          end
        end
      end
      ISSUE: begin
        if (!core_halted) begin
          state_next     = RESP;
          rsp_error_next = 1'b1;
          rsp_data_next  = 32'h0;
        end else if (inst_ready) begin
          state_next = WAIT;
`ifdef LADYBIRD_INJECT_TIMEOUT_EN
          tmo_next   = '0;
`endif
        end
      end
      WAIT: begin
        if (retire_valid) begin
          if (cap_save0) save0_next = retire_data;
          if (cap_save1) save1_next = retire_data;
          if (cap_rsp) rsp_data_next = retire_data;
          if (step_last) begin
            state_next = RESP;
          end else begin
            step_next  = step_reg + 4'd1;
            state_next = ISSUE;
          end
        end
`ifdef LADYBIRD_INJECT_TIMEOUT_EN
        else if (tmo_reg == TIMEOUT_LAST) begin
          state_next     = RESP;
          rsp_error_next = 1'b1;
          rsp_data_next  = 32'h0;
        end else begin
          tmo_next = tmo_reg + 32'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          step_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      op_reg        <= '0;
      regno_reg     <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      save0_reg     <= '0;
      save1_reg     <= '0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 1'b0;
`ifdef LADYBIRD_INJECT_TIMEOUT_EN
      tmo_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      op_reg        <= op_next;
      regno_reg     <= regno_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      save0_reg     <= save0_next;
      save1_reg     <= save1_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_error_reg <= rsp_error_next;
`ifdef LADYBIRD_INJECT_TIMEOUT_EN
      tmo_reg       <= tmo_next;
`endif
    end
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign inst_valid = (state_reg == ISSUE) && core_halted;
  assign inst       = inst_valid ? cur_inst : 32'h0;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_error  = rsp_error_reg;

endmodule

// File: tb/tb_ladybird_debug_injector.sv
// Directed testbench for ladybird_debug_injector with a simple core model
// that accepts (optionally after a stall) and retires injected instructions.
module tb_ladybird_debug_injector;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_regno;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        core_halted;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        retire_valid;
  logic [31:0] retire_data;

  ladybird_debug_injector #(
    .SCRATCH0(5'd30),
    .SCRATCH1(5'd31),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_regno   (cmd_regno),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .core_halted (core_halted),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .retire_valid(retire_valid),
    .retire_data (retire_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_pass;

  // core model state
  bit          auto_retire;
  int          stall_left;
  logic [31:0] rdat [16];
  logic [31:0] iss [32];
  int          n_iss;
  int          iv_seen;
  int          unstable;
  bit          pend;
  logic [31:0] pend_data;
  bit          prev_stalled;
  logic [31:0] prev_inst;

  // results of the last do_cmd
  logic [31:0] r_data;
  logic        r_err;
  int          lat;

  logic [31:0] exp_mw [10] = '{32'h000F0F13, 32'h000F8F93, 32'h80000F37, 32'h010F0F13,
                               32'h0A500F93, 32'h01FF0023, 32'h11111F37, 32'h111F0F13,
                               32'hCAFEFFB7, 32'h00DF8F93};
  logic [31:0] exp_mr [6]  = '{32'h000F0F13, 32'h00001F37, 32'hABCF0F13, 32'h000F0F03,
                               32'h80000F37, 32'h800F0F13};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_rdat();
    for (int i = 0; i < 16; i++) rdat[i] = 32'h0;
  endtask

  // Core model: everything happens at the falling edge so the DUT sees stable inputs
  initial begin
    inst_ready   = 1'b0;
    retire_valid = 1'b0;
    retire_data  = 32'h0;
    pend         = 1'b0;
    pend_data    = 32'h0;
    prev_stalled = 1'b0;
    prev_inst    = 32'h0;
    forever begin
      @(negedge clk);
      retire_valid = pend;
      retire_data  = pend ? pend_data : 32'h0;
      pend = 1'b0;
      if (inst_valid) iv_seen++;
      if (prev_stalled && inst_valid && (inst !== prev_inst)) unstable++;
      if (inst_valid && stall_left > 0) begin
        inst_ready = 1'b0;
        stall_left--;
      end else begin
        inst_ready = 1'b1;
      end
      prev_stalled = inst_valid && !inst_ready;
      prev_inst    = inst;
      if (inst_valid && inst_ready) begin
        if (n_iss < 32) iss[n_iss] = inst;
        pend      = auto_retire;
        pend_data = rdat[n_iss & 15];
        n_iss++;
      end
    end
  end

  // Run one command to completion; rsp_ready is held low for 'hold' cycles
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] regno,
                        input logic [31:0] addr, input logic [31:0] data, input int hold);
    bit done;
    @(negedge clk);
    n_iss = 0; iv_seen = 0; unstable = 0;
    chk("cmd_ready_before", cmd_ready, 1'b1);
    cmd_op = op; cmd_regno = regno; cmd_addr = addr; cmd_data = data;
    cmd_valid = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      cmd_valid = 1'b0;
      if (rsp_valid) done = 1'b1;
    end
    if (!done) begin
      chk("rsp_wait_expired", 32'd0, 32'd1);
      r_data = 32'h0; r_err = 1'b0;
    end else begin
      r_data = rsp_data;
      r_err  = rsp_error;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== r_data || rsp_error !== r_err) unstable++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_after", rsp_valid, 1'b0);
      chk("cmd_ready_after", cmd_ready, 1'b1);
    end
    $display("cmd op=%0d regno=%0d addr=%h data=%h -> rsp_data=%h err=%0d lat=%0d insts=%0d",
             op, regno, addr, data, r_data, r_err, lat, n_iss);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_regno = 5'd0; cmd_addr = 32'h0; cmd_data = 32'h0;
    rsp_ready = 1'b0; core_halted = 1'b1;
    auto_retire = 1'b1; stall_left = 0; n_iss = 0; iv_seen = 0; unstable = 0;
    clear_rdat();

    // reset state, observed while rst is still high
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    rst = 1'b0;

    // REG_WRITE x5 = 0x1234_5FFF: LUI/ADDI with ADDI sign-extension compensation
    clear_rdat();
    do_cmd(2'd1, 5'd5, 32'h0, 32'h1234_5FFF, 0);
    chk("rw_count", n_iss, 2);
    chk("rw_lui", iss[0], 32'h1234_62B7);
    chk("rw_addi", iss[1], 32'hFFF2_8293);
    chk("rw_data", r_data, 32'h1234_5FFF);
    chk("rw_err", r_err, 1'b0);
    chk("rw_lat", lat, 5);

    // REG_READ x10, best-case latency
    clear_rdat(); rdat[0] = 32'hDEAD_BEEF;
    do_cmd(2'd0, 5'd10, 32'h0, 32'h0, 0);
    chk("rr_count", n_iss, 1);
    chk("rr_inst", iss[0], 32'h0005_0513);
    chk("rr_lat", lat, 3);
    chk("rr_data", r_data, 32'hDEAD_BEEF);
    chk("rr_err", r_err, 1'b0);

    // MEM_WRITE_B: only data[7:0] is used; scratch values restored from captures
    clear_rdat(); rdat[0] = 32'h1111_1111; rdat[1] = 32'hCAFE_F00D;
    do_cmd(2'd3, 5'd0, 32'h8000_0010, 32'h1234_56A5, 0);
    chk("mw_count", n_iss, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("mw_inst%0d", i), iss[i], exp_mw[i]);
    chk("mw_data", r_data, 32'h0);
    chk("mw_err", r_err, 1'b0);
    chk("mw_lat", lat, 21);

    // MEM_READ_B: restore value 0x7FFF_F800 exercises the wrapping 0x800 bias
    clear_rdat(); rdat[0] = 32'h7FFF_F800; rdat[3] = 32'hFFFF_FF85;
    do_cmd(2'd2, 5'd0, 32'h0000_0ABC, 32'h0, 0);
    chk("mr_count", n_iss, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("mr_inst%0d", i), iss[i], exp_mr[i]);
    chk("mr_data", r_data, 32'hFFFF_FF85);
    chk("mr_err", r_err, 1'b0);

    // back-pressure: inst_ready low 5 cycles, then rsp_ready low 3 cycles
    clear_rdat(); rdat[0] = 32'h0BAD_F00D; stall_left = 5;
    do_cmd(2'd0, 5'd1, 32'h0, 32'h0, 3);
    chk("bp_count", n_iss, 1);
    chk("bp_inst", iss[0], 32'h0000_8093);
    chk("bp_stable", unstable, 0);
    chk("bp_lat", lat, 8);
    chk("bp_data", r_data, 32'h0BAD_F00D);
    stall_left = 0;

    // command while the core is running: immediate error response
    core_halted = 1'b0;
    do_cmd(2'd1, 5'd5, 32'h0, 32'h5555_AAAA, 0);
    chk("nh_inst_valid_seen", iv_seen, 0);
    chk("nh_lat", lat, 1);
    chk("nh_err", r_err, 1'b1);
    chk("nh_data", r_data, 32'h0);
    core_halted = 1'b1;

    // core leaves halt while an instruction is being offered
    stall_left = 100;
    @(negedge clk);
    n_iss = 0;
    cmd_op = 2'd0; cmd_regno = 5'd7; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("drop_pre_valid", inst_valid, 1'b1);
    core_halted = 1'b0;
    #1;
    chk("drop_withdraw", inst_valid, 1'b0);
    @(negedge clk);
    chk("drop_rsp_valid", rsp_valid, 1'b1);
    chk("drop_err", rsp_error, 1'b1);
    chk("drop_data", rsp_data, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; core_halted = 1'b1; stall_left = 0;
    chk("drop_no_issue", n_iss, 0);
    chk("drop_idle", cmd_ready, 1'b1);

`ifdef LADYBIRD_INJECT_TIMEOUT_EN
    // MEM_READ_B that never retires: error after 8 WAIT cycles
    auto_retire = 1'b0; clear_rdat();
    do_cmd(2'd2, 5'd0, 32'h0000_0100, 32'h0, 0);
    chk("to_count", n_iss, 1);
    chk("to_err", r_err, 1'b1);
    chk("to_data", r_data, 32'h0);
    chk("to_lat", lat, 10);
    auto_retire = 1'b1;
`endif

    // asynchronous reset in the middle of a MEM_READ_B (second step on offer)
    clear_rdat(); rdat[0] = 32'h2222_2222;
    @(negedge clk);
    n_iss = 0;
    cmd_op = 2'd2; cmd_addr = 32'h0000_0040; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_inst", inst, 32'h0000_0F37);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_inst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_data", rsp_data, 32'h0);
    chk("mid_rst_rsp_error", rsp_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // block restarts cleanly from step 0 after the abort
    clear_rdat(); rdat[0] = 32'h600D_CAFE;
    do_cmd(2'd0, 5'd3, 32'h0, 32'h0, 0);
    chk("post_rst_count", n_iss, 1);
    chk("post_rst_inst", iss[0], 32'h0001_8193);
    chk("post_rst_data", r_data, 32'h600D_CAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
